// File: rtl/qpd_pkg.sv
// Shared types and defaults for the qpd_multi trigger sequencer.
package qpd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int N_CH_DEF  = 4;
  localparam int CNT_W_DEF = 16;
  localparam int PW_W_DEF  = 8;
  localparam int PW_MIN    = 1;

endpackage

// File: rtl/qpd_channel.sv
// One trigger lane: registered pulse while the shared counter sits inside
// this lane's window [delay, delay+pw_eff-1].
module qpd_channel
  import qpd_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PW_W  = PW_W_DEF
) (
  input  logic                     sclock,
  input  logic                     rstn,
  input  logic [CNT_W-1:0]         delay,
  input  logic [PW_W-1:0]          pw_eff,
  input  logic [CNT_W+PW_W:0]      counter,
  input  logic                     run,
  output logic                     trigger
);

  localparam int CTR_W = CNT_W + PW_W + 1;

  logic [CTR_W-1:0] win_lo;
  logic [CTR_W-1:0] win_hi;
  logic             in_win;

  // Counter is wide enough that win_hi can never wrap.
  assign win_lo = CTR_W'(delay);
  assign win_hi = CTR_W'(delay) + CTR_W'(pw_eff);
  assign in_win = (counter >= win_lo) && (counter < win_hi);

  always_ff @(posedge sclock or negedge rstn) begin
    if (!rstn) begin
      trigger <= 1'b0;
    end else begin
      trigger <= run && in_win;
    end
  end

endmodule

// File: rtl/qpd_multi.sv
// Multi-channel programmable-delay trigger sequencer.
// Optional build macro QPD_RETRIGGER_EN: re-fire on every rt request, not only on new delays.
module qpd_multi
  import qpd_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int PW_W  = PW_W_DEF
) (
  input  logic                    sclock,
  input  logic                    rstn,
  input  logic                    en,
  input  logic                    rt,
  input  logic [N_CH*CNT_W-1:0]   delays,
  input  logic [PW_W-1:0]         pulse_width,
  output logic [N_CH-1:0]         trigger,
  output logic                    busy,
  output logic                    done
);

  localparam int CTR_W = CNT_W + PW_W + 1;

  state_t                  state;
  state_t                  state_nxt;
  logic [CTR_W-1:0]        counter;
  logic [N_CH*CNT_W-1:0]   last_cfg;
  logic [N_CH*CNT_W-1:0]   dly_sh;
  logic [PW_W-1:0]         pw_sh;
  logic [CNT_W-1:0]        max_d;
  logic [CTR_W-1:0]        end_cnt;
  logic                    req;
  logic                    load;
  logic                    run;
  logic                    finish;

  function automatic logic [PW_W-1:0] pw_clamp(input logic [PW_W-1:0] pw);
    if (pw < PW_W'(PW_MIN)) return PW_W'(PW_MIN);
    return pw;
  endfunction

`ifdef QPD_RETRIGGER_EN
  assign req = en & rt;
`else
  assign req = en & rt & (delays != last_cfg);
`endif

  always_comb begin
    max_d = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (dly_sh[c*CNT_W +: CNT_W] > max_d) max_d = dly_sh[c*CNT_W +: CNT_W];
    end
  end

  assign end_cnt = CTR_W'(max_d) + CTR_W'(pw_sh);
  assign run     = en && (state == RUN);
  assign finish  = run && (counter == end_cnt);
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (req) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
        RUN:  if (finish) state_nxt = HOLD;
        HOLD: if (!rt) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge sclock or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Counter idles at zero, so a load needs no explicit clear.
  always_ff @(posedge sclock or negedge rstn) begin
    if (!rstn) begin
      counter  <= '0;
      last_cfg <= '0;
      done     <= 1'b0;
    end else begin
      done    <= finish;
      counter <= run ? counter + CTR_W'(1) : '0;
      if (load) last_cfg <= delays;
    end
  end

  // Shadow copy of the configuration; only consumed while run is high.
  always_ff @(posedge sclock) begin
    if (load) begin
      dly_sh <= delays;
      pw_sh  <= pw_clamp(pulse_width);
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    qpd_channel #(
      .CNT_W (CNT_W),
      .PW_W  (PW_W)
    ) u_ch (
      .sclock  (sclock),
      .rstn    (rstn),
      .delay   (dly_sh[c*CNT_W +: CNT_W]),
      .pw_eff  (pw_sh),
      .counter (counter),
      .run     (run),
      .trigger (trigger[c])
    );
  end

endmodule

// File: doc/qpd_multi.md
# qpd_multi

Multi-channel programmable-delay trigger sequencer; parametrised successor to the single-channel quarter-period delay block. On a trigger request (`rt`) accompanied by a new delay configuration, it fires one pulse per channel, each offset by its own programmed delay from a common start, then reports completion. It sits between the C-server-written configuration registers and the acquisition front end, generating staggered sampling/phase triggers.

## Interface
- `N_CH`, 4, number of trigger channels (1..16)
- `CNT_W`, 16, width of each per-channel delay in `sclock` cycles
- `PW_W`, 8, width of the pulse-width field
- `sclock` in 1, sample clock; all logic on rising edge
- `rstn` in 1, asynchronous, active-low reset
- `en` in 1, block enable; low forces IDLE
- `rt` in 1, request-trigger level from the control path
- `delays` in N_CH*CNT_W, per-channel delay; channel c at bits [c*CNT_W +: CNT_W]
- `pulse_width` in PW_W, trigger high time in cycles; 0 treated as 1
- `trigger` out N_CH, per-channel trigger pulses (registered)
- `busy` out 1, high in RUN and HOLD
- `done` out 1, one-cycle strobe at end of a sequence

## Operation
- States: IDLE, RUN, HOLD.
- IDLE: request = `en` & `rt` & (`delays` != `last_cfg`). On request: shadow `delays` and `pulse_width` (pw_eff = max(pulse_width,1)), `last_cfg` <= `delays`, counter <= 0, go RUN.
- RUN: counter (CNT_W+PW_W+1 bits, no wrap possible) increments each cycle. `trigger[c]` high after any edge where counter in [d[c], d[c]+pw_eff-1]. At the edge where counter == max(d)+pw_eff: all triggers low, `done` high for one cycle, go HOLD.
- HOLD: wait for `rt` == 0, then IDLE. Prevents refiring on a held request.
- Config changes on `delays`/`pulse_width` during RUN/HOLD are ignored for the running sequence; they are compared against `last_cfg` on return to IDLE.
- `rt` falling during RUN does not abort.
- `en` low in any state: next edge state = IDLE, triggers/done/busy low, counter 0; `last_cfg` retained.
- Channels with equal delays pulse simultaneously.

## Timing
- Reset: state IDLE, `trigger` = 0, `busy` = 0, `done` = 0, counter = 0, `last_cfg` = 0 (an all-zero config after reset does not fire).
- Edge E0 samples request -> `busy` high after E0.
- `trigger[c]` rises after edge E0+d[c]+1 and is high exactly pw_eff cycles.
- `done` high during cycle after edge E0+max(d)+pw_eff+1; `busy` stays high through HOLD.
- Minimum sequence (all d=0, pw=1): triggers high after E1, `done` after E2.
- HOLD->IDLE one edge after `rt` sampled low; a new request is accepted no earlier than the following edge.

## Configuration
- `QPD_RETRIGGER_EN` defined: IDLE request = `en` & `rt`, config-change check removed; each rt low->high cycle re-fires with current config (`last_cfg` still updated).
- Not defined: fire only when `delays` differs from `last_cfg` (one sequence per new parameter set).

## Structure
- Package `qpd_pkg`: state enum (IDLE, RUN, HOLD), default widths, `PW_MIN` = 1.
- Sub-module `qpd_channel`: one per channel (generate loop); inputs shadowed delay, pw_eff, counter, run; output registered trigger bit. Top holds FSM, counter, shadow regs, max-delay reduction.

## Test plan
- Reset then `delays`={0,8,16,24} (N_CH=4), pw=2, `rt`=1 -> trigger[0..3] rise after E0+1/9/17/25, each 2 cycles; `done` after E0+27.
- Hold `rt`=1 after done, same config -> no further triggers; drop `rt`, reassert -> still none (macro undefined); with `QPD_RETRIGGER_EN` -> second full sequence.
- Change `delays[1]` from 8 to 12 mid-RUN -> current sequence uses 8; after HOLD->IDLE with `rt`=1 -> new sequence with 12.
- `pulse_width`=0, all delays 5 -> all four triggers high together for exactly 1 cycle after E0+6.
- `en` dropped at counter=10 of a run -> next edge all triggers/busy low, no `done`; re-enable with unchanged config -> no fire.
- Assert `rstn` low mid-pulse -> outputs 0 immediately (async); after release, all-zero `delays` with `rt`=1 -> no fire.
